// File: rtl/div_secuencial.sv
// Sequential restoring divider for RV32 DIV/DIVU/REM/REMU: operands are latched as magnitudes,
// one quotient bit is resolved per cycle, and signs are restored in a final adjust cycle.

module fn_suma_resta #(
  parameter int ANCHO = 33
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             resta,
  output logic [ANCHO-1:0] Y
);
  assign Y = resta ? (a - b) : (a + b);
endmodule

module div_secuencial #(
  parameter int ANCHO = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic             con_signo,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic             ocupado,
  output logic             valido,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] resto
);
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {INACTIVO, CALCULO, AJUSTE} estado_t;

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [ANCHO-1:0] r_rem;
  logic [ANCHO-1:0] r_q;
  logic [ANCHO-1:0] r_div;
  logic [ANCHO-1:0] r_a_orig;
  logic             r_sq;
  logic             r_sr;
  logic             r_cero;
  logic             r_valido;
  logic [ANCHO-1:0] r_cociente;
  logic [ANCHO-1:0] r_resto;

  logic             w_sa;
  logic             w_sb;
  logic [ANCHO:0]   w_rem_sh;
  logic [ANCHO:0]   w_dif;
  logic             w_acepta;
  logic             w_cnt_fin;

  function automatic logic [ANCHO-1:0] neg_cond(input logic [ANCHO-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  assign w_sa      = con_signo & a[ANCHO-1];
  assign w_sb      = con_signo & b[ANCHO-1];
  assign w_rem_sh  = {r_rem, r_q[ANCHO-1]};
  assign w_acepta  = ~w_dif[ANCHO];
  assign w_cnt_fin = (r_cnt == CNT_W'(ITER - 1));

  fn_suma_resta #(.ANCHO(ANCHO + 1)) u_resta (
    .a     (w_rem_sh),
    .b     ({1'b0, r_div}),
    .resta (1'b1),
    .Y     (w_dif)
  );

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      INACTIVO: if (inicio) w_estado_sig = CALCULO;
      CALCULO:  if (w_cnt_fin) w_estado_sig = AJUSTE;
      AJUSTE:   w_estado_sig = INACTIVO;
      default:  w_estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_estado <= INACTIVO;
    else       r_estado <= w_estado_sig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_valido   <= 1'b0;
      r_cociente <= '0;
      r_resto    <= '0;
    end else begin
      r_valido <= (r_estado == AJUSTE);
      case (r_estado)
        INACTIVO: if (inicio) r_cnt <= '0;
        CALCULO:  r_cnt <= r_cnt + 1'b1;
        AJUSTE: begin
          // Divide-by-zero returns all-ones and the untouched dividend, never sign-corrected
          if (r_cero) begin
            r_cociente <= '1;
            r_resto    <= r_a_orig;
          end else begin
            r_cociente <= neg_cond(r_q, r_sq);
            r_resto    <= neg_cond(r_rem, r_sr);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_estado == INACTIVO && inicio) begin
      r_q      <= neg_cond(a, w_sa);
      r_div    <= neg_cond(b, w_sb);
      r_rem    <= '0;
      r_sq     <= w_sa ^ w_sb;
      r_sr     <= w_sa;
      r_cero   <= (b == '0);
      r_a_orig <= a;
    end else if (r_estado == CALCULO) begin
      r_rem <= w_acepta ? w_dif[ANCHO-1:0] : w_rem_sh[ANCHO-1:0];
      r_q   <= {r_q[ANCHO-2:0], w_acepta};
    end
  end

  assign ocupado  = (r_estado != INACTIVO);
  assign valido   = r_valido;
  assign cociente = r_cociente;
  assign resto    = r_resto;
endmodule

// File: tb/tb_div_secuencial.sv
// Bench for div_secuencial: directed corner cases plus randomized operands against an arithmetic
// reference built from the RV32 division rules.

module tb_div_secuencial;
  logic        clk;
  logic        reset;
  logic        inicio;
  logic        con_signo;
  logic [31:0] a;
  logic [31:0] b;
  logic        ocupado;
  logic        valido;
  logic [31:0] cociente;
  logic [31:0] resto;

  int vectors;
  int miscompares;

  div_secuencial #(.ANCHO(32), .ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .con_signo (con_signo),
    .a         (a),
    .b         (b),
    .ocupado   (ocupado),
    .valido    (valido),
    .cociente  (cociente),
    .resto     (resto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sx / sy;
        r = sx % sy;
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x;
    b = y;
    con_signo = s;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  // Counts edges after the start edge until valido is seen; -1 when the bound expires
  task automatic wait_done(input string tag, input bit scramble, input int base, output int lat);
    lat = -1;
    for (int i = base + 1; i <= base + 40; i++) begin
      tick();
      if (valido) begin
        lat = i;
        break;
      end
      chk({tag, " ocupado"}, {31'b0, ocupado}, 32'd1);
      if (scramble) begin
        a = $urandom;
        b = $urandom;
        con_signo = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    model(x, y, s, eq, er);
    start_op(x, y, s);
    chk({tag, " ocupado_start"}, {31'b0, ocupado}, 32'd1);
    wait_done(tag, 1'b1, 0, lat);
    chk({tag, " latency"}, 32'(lat), 32'd33);
    chk({tag, " cociente"}, cociente, eq);
    chk({tag, " resto"}, resto, er);
    tick();
    chk({tag, " valido_drop"}, {31'b0, valido}, 32'd0);
    chk({tag, " ocupado_end"}, {31'b0, ocupado}, 32'd0);
    chk({tag, " cociente_hold"}, cociente, eq);
  endtask

  initial begin
    int lat;
    int npulses;
    logic [31:0] rx;
    logic [31:0] ry;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    inicio = 1'b0;
    con_signo = 1'b0;
    a = '0;
    b = '0;

    repeat (3) tick();
    chk("reset ocupado", {31'b0, ocupado}, 32'd0);
    chk("reset valido", {31'b0, valido}, 32'd0);
    chk("reset cociente", cociente, 32'd0);
    chk("reset resto", resto, 32'd0);
    reset = 1'b0;
    tick();

    run_div(32'd100, 32'd7, 1'b0, "u100/7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7/2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7/-2");
    run_div(32'd5, 32'd0, 1'b0, "u5/0");
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, "s-5/0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_ovf");
    run_div(32'h8000_0000, 32'd1, 1'b1, "s_min/1");
    run_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "u_max/half");

    // A second inicio while busy must be ignored
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    a = 32'd9;
    b = 32'd3;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    wait_done("busy_start", 1'b0, 10, lat);
    chk("busy_start latency", 32'(lat), 32'd33);
    chk("busy_start cociente", cociente, 32'd14);
    chk("busy_start resto", resto, 32'd2);
    npulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valido) npulses++;
    end
    chk("busy_start extra_valido", 32'(npulses), 32'd0);

    // inicio in the valido cycle is accepted
    start_op(32'd100, 32'd7, 1'b0);
    wait_done("back2back_1", 1'b0, 0, lat);
    chk("back2back_1 latency", 32'(lat), 32'd33);
    chk("back2back_1 cociente", cociente, 32'd14);
    start_op(32'd9, 32'd3, 1'b0);
    chk("back2back valido_drop", {31'b0, valido}, 32'd0);
    chk("back2back ocupado", {31'b0, ocupado}, 32'd1);
    chk("back2back cociente_held", cociente, 32'd14);
    chk("back2back resto_held", resto, 32'd2);
    wait_done("back2back_2", 1'b1, 1, lat);
    chk("back2back_2 distance", 32'(lat), 32'd34);
    chk("back2back_2 cociente", cociente, 32'd3);
    chk("back2back_2 resto", resto, 32'd0);
    tick();

    // Reset mid-operation discards the division
    start_op(32'd1000, 32'd9, 1'b0);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    chk("midreset ocupado", {31'b0, ocupado}, 32'd0);
    chk("midreset valido", {31'b0, valido}, 32'd0);
    chk("midreset cociente", cociente, 32'd0);
    chk("midreset resto", resto, 32'd0);
    reset = 1'b0;
    npulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valido || ocupado) npulses++;
    end
    chk("midreset no_activity", 32'(npulses), 32'd0);
    run_div(32'd1000, 32'd9, 1'b0, "after_reset");

    for (int n = 0; n < 24; n++) begin
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: ry = 32'($urandom_range(1, 300));
        2: ry = 32'($signed(-$urandom_range(1, 300)));
        default: ry = (n % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
      endcase
      run_div(rx, ry, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
